// File: rtl/fpu_pkg.sv
// Shared encodings, op classes, FSM states and flag indices for the sequential FPU unit.
package fpu_pkg;

  localparam logic [3:0] OP_FADD   = 4'b0000;
  localparam logic [3:0] OP_FSUB   = 4'b0001;
  localparam logic [3:0] OP_FMUL   = 4'b0010;
  localparam logic [3:0] OP_FDIV   = 4'b0011;
  localparam logic [3:0] OP_FEQ    = 4'b0100;
  localparam logic [3:0] OP_FLT    = 4'b0101;
  localparam logic [3:0] OP_FLE    = 4'b0110;
  localparam logic [3:0] OP_FCVTWS = 4'b0111;
  localparam logic [3:0] OP_FCVTSW = 4'b1000;
  localparam logic [3:0] OP_FSGNJ  = 4'b1001;
  localparam logic [3:0] OP_FSGNJN = 4'b1010;
  localparam logic [3:0] OP_FSGNJX = 4'b1011;

  localparam int unsigned FLAGS_W = 5;
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {ADDSUB, MUL, DIV, MISC} op_class_e;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} fsm_state_e;

  // Latency class of an operation; illegal codes fall into MISC.
  function automatic op_class_e op_class(input logic [3:0] ctrl);
    case (ctrl)
      OP_FADD, OP_FSUB: return ADDSUB;
      OP_FMUL:          return MUL;
      OP_FDIV:          return DIV;
      default:          return MISC;
    endcase
  endfunction

endpackage

// File: rtl/FPU.sv
// Combinational single-precision datapath: RNE add/sub/mul/div, compares, converts, sign-inject.
// Subnormal inputs are treated as zero and underflowing results flush to zero.
module FPU
  import fpu_pkg::*;
(
  input  logic [31:0] OP_A,
  input  logic [31:0] OP_B,
  input  logic [3:0]  FPU_Control,
  output logic [31:0] Result
);

  // Index of the most significant set bit, as a left-shift amount to bit 50.
  function automatic logic [5:0] lzc51(input logic [50:0] v);
    logic [5:0] n;
    n = 6'd51;
    for (int i = 0; i < 51; i++) begin
      if (v[i]) n = 6'(50 - i);
    end
    return n;
  endfunction

  // Round-to-nearest-even and pack; mant has its leading one at bit 50.
  function automatic logic [31:0] round_pack(input logic sgn, input logic signed [10:0] exp,
                                             input logic [50:0] mant);
    logic              inc;
    logic [24:0]       m;
    logic signed [10:0] e;
    inc = mant[26] & ((|mant[25:0]) | mant[27]);
    m   = {1'b0, mant[50:27]} + 25'(inc);
    e   = exp;
    if (m[24]) begin
      m = m >> 1;
      e = e + 11'sd1;
    end
    if (e >= 11'sd255)   return {sgn, 8'hFF, 23'h0};
    else if (e <= 11'sd0) return {sgn, 31'h0};
    else                 return {sgn, e[7:0], m[22:0]};
  endfunction

  logic        a_s, b_s;
  logic [7:0]  a_e, b_e;
  logic [22:0] a_f, b_f;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [23:0] a_m, b_m;
  logic signed [10:0] ea, eb;

  assign {a_s, a_e, a_f} = OP_A;
  assign {b_s, b_e, b_f} = OP_B;
  assign a_zero = (a_e == 8'h00);
  assign b_zero = (b_e == 8'h00);
  assign a_inf  = (a_e == 8'hFF) && (a_f == 23'h0);
  assign b_inf  = (b_e == 8'hFF) && (b_f == 23'h0);
  assign a_nan  = (a_e == 8'hFF) && (a_f != 23'h0);
  assign b_nan  = (b_e == 8'hFF) && (b_f != 23'h0);
  assign a_m    = {1'b1, a_f};
  assign b_m    = {1'b1, b_f};
  assign ea     = $signed({3'b000, a_e});
  assign eb     = $signed({3'b000, b_e});

  logic [31:0] add_res, mul_res, div_res, cvtw_res, cvts_res;
  logic        add_sb, a_big, eff_sub;
  logic [7:0]  e_big, e_sml, e_diff;
  logic [23:0] m_big, m_sml;
  logic [49:0] big_al, sml_al;
  logic [50:0] add_mag, mul_ext, div_ext, int_ext;
  logic [5:0]  add_lz, mul_lz, div_lz, int_lz;
  logic [47:0] prod;
  logic [50:0] div_num, div_den;
  logic [27:0] quo;
  logic        rem_nz, prod_s;
  logic [31:0] cvt_mag, int_mag;
  logic        feq, flt;

  // Add/subtract: align the smaller magnitude; far-away operands collapse to a sticky bit.
  always_comb begin
    add_sb  = b_s ^ (FPU_Control == OP_FSUB);
    a_big   = {a_e, a_f} >= {b_e, b_f};
    e_big   = a_big ? a_e : b_e;
    e_sml   = a_big ? b_e : a_e;
    m_big   = a_big ? a_m : b_m;
    m_sml   = a_big ? b_m : a_m;
    eff_sub = a_s ^ add_sb;
    e_diff  = e_big - e_sml;
    big_al  = {m_big, 26'h0};
    sml_al  = (e_diff > 8'd26) ? 50'd1 : ({m_sml, 26'h0} >> e_diff);
    add_mag = eff_sub ? ({1'b0, big_al} - {1'b0, sml_al}) : ({1'b0, big_al} + {1'b0, sml_al});
    add_lz  = lzc51(add_mag);
    if (a_nan || b_nan)       add_res = QNAN;
    else if (a_inf && b_inf)  add_res = eff_sub ? QNAN : OP_A;
    else if (a_inf)           add_res = OP_A;
    else if (b_inf)           add_res = {add_sb, OP_B[30:0]};
    else if (a_zero && b_zero) add_res = {a_s & add_sb, 31'h0};
    else if (a_zero)          add_res = {add_sb, OP_B[30:0]};
    else if (b_zero)          add_res = OP_A;
    else if (add_mag == 51'h0) add_res = 32'h0;
    else add_res = round_pack(a_big ? a_s : add_sb,
                              $signed({3'b000, e_big}) + 11'sd1 - $signed({5'b0, add_lz}),
                              add_mag << add_lz);
  end

  // Multiply and divide share sign handling and the round/pack step.
  always_comb begin
    prod_s  = a_s ^ b_s;
    prod    = a_m * b_m;
    mul_ext = {prod, 3'b000};
    mul_lz  = lzc51(mul_ext);
    div_num = {a_m, 27'h0};
    div_den = {27'h0, b_m};
    quo     = 28'(div_num / div_den);
    rem_nz  = (div_num % div_den) != 51'h0;
    div_ext = {quo, 22'h0, rem_nz};
    div_lz  = lzc51(div_ext);

    if (a_nan || b_nan)                         mul_res = QNAN;
    else if ((a_inf && b_zero) || (a_zero && b_inf)) mul_res = QNAN;
    else if (a_inf || b_inf)                    mul_res = {prod_s, 8'hFF, 23'h0};
    else if (a_zero || b_zero)                  mul_res = {prod_s, 31'h0};
    else mul_res = round_pack(prod_s, ea + eb - 11'sd126 - $signed({5'b0, mul_lz}),
                              mul_ext << mul_lz);

    if (a_nan || b_nan)                          div_res = QNAN;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) div_res = QNAN;
    else if (a_inf || b_zero)                    div_res = {prod_s, 8'hFF, 23'h0};
    else if (a_zero || b_inf)                    div_res = {prod_s, 31'h0};
    else div_res = round_pack(prod_s, ea - eb + 11'sd127 - $signed({5'b0, div_lz}),
                              div_ext << div_lz);
  end

  // Conversions: float->int truncates toward zero and saturates; int->float rounds RNE.
  always_comb begin
    if (a_e >= 8'd150) cvt_mag = {8'h0, a_m} << (a_e - 8'd150);
    else               cvt_mag = {8'h0, a_m} >> (8'd150 - a_e);
    if (a_nan)              cvtw_res = 32'h7FFF_FFFF;
    else if (a_e < 8'd127)  cvtw_res = 32'h0;
    else if (a_e >= 8'd158) cvtw_res = a_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else                    cvtw_res = a_s ? -cvt_mag : cvt_mag;

    int_mag = OP_A[31] ? -OP_A : OP_A;
    int_ext = {int_mag, 19'h0};
    int_lz  = lzc51(int_ext);
    if (OP_A == 32'h0) cvts_res = 32'h0;
    else cvts_res = round_pack(OP_A[31], 11'sd158 - $signed({5'b0, int_lz}), int_ext << int_lz);
  end

  always_comb begin
    feq = !(a_nan || b_nan) && ((a_zero && b_zero) || (OP_A == OP_B));
    if (a_nan || b_nan || (a_zero && b_zero)) flt = 1'b0;
    else if (a_s != b_s)                      flt = a_s;
    else if (!a_s)                            flt = OP_A[30:0] < OP_B[30:0];
    else                                      flt = OP_A[30:0] > OP_B[30:0];
  end

  always_comb begin
    case (FPU_Control)
      OP_FADD, OP_FSUB: Result = add_res;
      OP_FMUL:          Result = mul_res;
      OP_FDIV:          Result = div_res;
      OP_FEQ:           Result = {31'h0, feq};
      OP_FLT:           Result = {31'h0, flt};
      OP_FLE:           Result = {31'h0, flt | feq};
      OP_FCVTWS:        Result = cvtw_res;
      OP_FCVTSW:        Result = cvts_res;
      OP_FSGNJ:         Result = {b_s, OP_A[30:0]};
      OP_FSGNJN:        Result = {~b_s, OP_A[30:0]};
      OP_FSGNJX:        Result = {a_s ^ b_s, OP_A[30:0]};
      default:          Result = 32'h0;
    endcase
  end

endmodule

// File: rtl/fpu_seq_unit.sv
// Valid/ready wrapper around the FPU datapath with per-class latency, sticky NV/DZ flags
// and tag passthrough. One operation in flight at a time.
module fpu_seq_unit
  import fpu_pkg::*;
#(
  parameter int unsigned ADD_LAT  = 2,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 8,
  parameter int unsigned MISC_LAT = 1,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      OP_A,
  input  logic [31:0]      OP_B,
  input  logic [3:0]       FPU_Control,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      Result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       fflags,
  input  logic             fflags_clr
);

  localparam int unsigned MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int unsigned MAX_DM  = (DIV_LAT > MISC_LAT) ? DIV_LAT : MISC_LAT;
  localparam int unsigned MAX_LAT = (MAX_AM > MAX_DM) ? MAX_AM : MAX_DM;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  fsm_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [TAG_W-1:0]   tag_q, tag_d, out_tag_q, out_tag_d;
  logic [31:0]        result_q, result_d;
  logic [FLAGS_W-1:0] fflags_q, fflags_d;

  logic               accept;
  logic [CNT_W-1:0]   lat_m1;
  logic [31:0]        fpu_result;
  logic [FLAGS_W-1:0] new_flags;
  logic               a_snan, b_snan, a_zero, b_zero, a_special, nan_checked;

  FPU u_fpu (
    .OP_A        (a_q),
    .OP_B        (b_q),
    .FPU_Control (ctrl_q),
    .Result      (fpu_result)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;
  assign out_tag   = out_tag_q;
  assign fflags    = fflags_q;

  always_comb begin
    case (op_class(FPU_Control))
      ADDSUB:  lat_m1 = CNT_W'(ADD_LAT - 1);
      MUL:     lat_m1 = CNT_W'(MUL_LAT - 1);
      DIV:     lat_m1 = CNT_W'(DIV_LAT - 1);
      default: lat_m1 = CNT_W'(MISC_LAT - 1);
    endcase
  end

  // Exception detection on the captured operands; zero means exponent 0 to match the datapath.
  always_comb begin
    a_snan      = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0) && !a_q[22];
    b_snan      = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0) && !b_q[22];
    a_zero      = (a_q[30:23] == 8'h00);
    b_zero      = (b_q[30:23] == 8'h00);
    a_special   = (a_q[30:23] == 8'hFF);
    nan_checked = (op_class(ctrl_q) != MISC) ||
                  (ctrl_q == OP_FEQ) || (ctrl_q == OP_FLT) || (ctrl_q == OP_FLE);
    new_flags          = '0;
    new_flags[FLAG_NV] = (ctrl_q[3:2] == 2'b11) ||
                         (nan_checked && (a_snan || b_snan)) ||
                         ((ctrl_q == OP_FDIV) && a_zero && b_zero);
    new_flags[FLAG_DZ] = (ctrl_q == OP_FDIV) && b_zero && !a_zero && !a_special;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    ctrl_d    = ctrl_q;
    tag_d     = tag_q;
    result_d  = result_q;
    out_tag_d = out_tag_q;
    fflags_d  = fflags_clr ? '0 : fflags_q;

    if (accept) begin
      a_d    = OP_A;
      b_d    = OP_B;
      ctrl_d = FPU_Control;
      tag_d  = in_tag;
      cnt_d  = lat_m1;
    end

    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
        if (cnt_q == '0) begin
          state_d   = DONE;
          result_d  = fpu_result;
          out_tag_d = tag_q;
          // A flag raised in the same cycle as a clear survives the clear.
          fflags_d  = fflags_clr ? new_flags : (fflags_q | new_flags);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (accept)         state_d = EXEC;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ctrl_q    <= '0;
      tag_q     <= '0;
      result_q  <= '0;
      out_tag_q <= '0;
      fflags_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctrl_q    <= ctrl_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      out_tag_q <= out_tag_d;
      fflags_q  <= fflags_d;
    end
  end

endmodule

// File: tb/tb_fpu_seq_unit.sv
// Directed self-checking bench for fpu_seq_unit with default latencies (2/3/8/1).
module tb_fpu_seq_unit;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] OP_A;
  logic [31:0] OP_B;
  logic [3:0]  FPU_Control;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic [4:0]  out_tag;
  logic [4:0]  fflags;
  logic        fflags_clr;

  int total;
  int bad;

  fpu_seq_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .OP_A        (OP_A),
    .OP_B        (OP_B),
    .FPU_Control (FPU_Control),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Result      (Result),
    .out_tag     (out_tag),
    .fflags      (fflags),
    .fflags_clr  (fflags_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Cycles from the accept edge until out_valid, or -1 if it never arrives.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) n = -1;
  endtask

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output int n);
    FPU_Control = c;
    OP_A        = a;
    OP_B        = b;
    in_tag      = tag;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic clear_flags();
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    total++; if (in_ready !== 1'b1)     begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (Result !== 32'h0)      begin bad++; $display("FAIL reset_result got=%h exp=0", Result); end
    total++; if (out_tag !== 5'h0)      begin bad++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    total++; if (fflags !== 5'b00000)   begin bad++; $display("FAIL reset_fflags got=%b exp=00000", fflags); end
  endtask

  task automatic test_add();
    int n;
    run_op(4'b0000, 32'h3F80_0000, 32'h4000_0000, 5'd3, n);
    total++; if (n !== 2)               begin bad++; $display("FAIL add_latency got=%0d exp=2", n); end
    total++; if (Result !== 32'h4040_0000) begin bad++; $display("FAIL add_result got=%h exp=40400000", Result); end
    total++; if (out_tag !== 5'd3)      begin bad++; $display("FAIL add_tag got=%0d exp=3", out_tag); end
    total++; if (fflags !== 5'b00000)   begin bad++; $display("FAIL add_fflags got=%b exp=00000", fflags); end
    consume();
    total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL add_consumed got=%b exp=0", out_valid); end
    run_op(4'b0001, 32'h4040_0000, 32'h3F80_0000, 5'd4, n);
    total++; if (n !== 2)               begin bad++; $display("FAIL sub_latency got=%0d exp=2", n); end
    total++; if (Result !== 32'h4000_0000) begin bad++; $display("FAIL sub_result got=%h exp=40000000", Result); end
    consume();
  endtask

  task automatic test_misc();
    int n;
    logic [3:0]  ctl [5];
    logic [31:0] va  [5];
    logic [31:0] vb  [5];
    logic [31:0] exp_r [5];
    ctl[0] = 4'b0100; va[0] = 32'h3F80_0000; vb[0] = 32'h3F80_0000; exp_r[0] = 32'h1;
    ctl[1] = 4'b0101; va[1] = 32'h3F80_0000; vb[1] = 32'h4000_0000; exp_r[1] = 32'h1;
    ctl[2] = 4'b0111; va[2] = 32'h4040_0000; vb[2] = 32'h0;         exp_r[2] = 32'd3;
    ctl[3] = 4'b1000; va[3] = 32'd5;         vb[3] = 32'h0;         exp_r[3] = 32'h40A0_0000;
    ctl[4] = 4'b1010; va[4] = 32'h3F80_0000; vb[4] = 32'h3F80_0000; exp_r[4] = 32'hBF80_0000;

    run_op(4'b1111, 32'h3F80_0000, 32'h3F80_0000, 5'd6, n);
    total++; if (n !== 1)               begin bad++; $display("FAIL illegal_latency got=%0d exp=1", n); end
    total++; if (Result !== 32'h0)      begin bad++; $display("FAIL illegal_result got=%h exp=0", Result); end
    total++; if (fflags !== 5'b10000)   begin bad++; $display("FAIL illegal_nv got=%b exp=10000", fflags); end
    consume();
    clear_flags();
    total++; if (fflags !== 5'b00000)   begin bad++; $display("FAIL clr_alone got=%b exp=00000", fflags); end

    run_op(4'b0100, 32'h7FA0_0000, 32'h3F80_0000, 5'd7, n);
    total++; if (Result !== 32'h0)      begin bad++; $display("FAIL feq_snan_result got=%h exp=0", Result); end
    total++; if (fflags !== 5'b10000)   begin bad++; $display("FAIL feq_snan_nv got=%b exp=10000", fflags); end
    consume();
    clear_flags();

    run_op(4'b0100, 32'h7FC0_0000, 32'h7FC0_0000, 5'd8, n);
    total++; if (fflags !== 5'b00000)   begin bad++; $display("FAIL feq_qnan_quiet got=%b exp=00000", fflags); end
    consume();

    for (int i = 0; i < 5; i++) begin
      run_op(ctl[i], va[i], vb[i], 5'(i), n);
      total++; if (n !== 1)             begin bad++; $display("FAIL misc_lat[%0d] got=%0d exp=1", i, n); end
      total++; if (Result !== exp_r[i]) begin bad++; $display("FAIL misc_result[%0d] got=%h exp=%h", i, Result, exp_r[i]); end
      consume();
    end
  endtask

  task automatic test_div();
    int n;
    run_op(4'b0011, 32'h40C0_0000, 32'h4040_0000, 5'd1, n);
    total++; if (n !== 8)               begin bad++; $display("FAIL div_latency got=%0d exp=8", n); end
    total++; if (Result !== 32'h4000_0000) begin bad++; $display("FAIL div_6_3 got=%h exp=40000000", Result); end
    total++; if (fflags !== 5'b00000)   begin bad++; $display("FAIL div_6_3_flags got=%b exp=00000", fflags); end
    consume();
    run_op(4'b0011, 32'h3F80_0000, 32'h0000_0000, 5'd2, n);
    total++; if (n !== 8)               begin bad++; $display("FAIL dz_latency got=%0d exp=8", n); end
    total++; if (Result !== 32'h7F80_0000) begin bad++; $display("FAIL dz_result got=%h exp=7f800000", Result); end
    total++; if (fflags !== 5'b01000)   begin bad++; $display("FAIL dz_flag got=%b exp=01000", fflags); end
    consume();
    run_op(4'b0011, 32'h0000_0000, 32'h0000_0000, 5'd3, n);
    total++; if (Result !== 32'h7FC0_0000) begin bad++; $display("FAIL div_0_0 got=%h exp=7fc00000", Result); end
    total++; if (fflags !== 5'b11000)   begin bad++; $display("FAIL div_0_0_sticky got=%b exp=11000", fflags); end
    consume();
  endtask

  task automatic test_reset_abort();
    int n;
    logic seen;
    FPU_Control = 4'b0011;
    OP_A        = 32'h3F80_0000;
    OP_B        = 32'h0;
    in_tag      = 5'd9;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1)     begin bad++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    total++; if (fflags !== 5'b00000)   begin bad++; $display("FAIL abort_fflags got=%b exp=00000", fflags); end
    total++; if (Result !== 32'h0)      begin bad++; $display("FAIL abort_result got=%h exp=0", Result); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0)         begin bad++; $display("FAIL abort_discard got=%b exp=0", seen); end
    run_op(4'b0010, 32'h4000_0000, 32'h4040_0000, 5'd10, n);
    total++; if (n !== 3)               begin bad++; $display("FAIL mul_latency got=%0d exp=3", n); end
    total++; if (Result !== 32'h40C0_0000) begin bad++; $display("FAIL mul_result got=%h exp=40c00000", Result); end
    total++; if (fflags !== 5'b00000)   begin bad++; $display("FAIL mul_flags got=%b exp=00000", fflags); end
    consume();
  endtask

  task automatic test_flag_clr();
    int n;
    run_op(4'b1100, 32'h0, 32'h0, 5'd0, n);
    consume();
    total++; if (fflags !== 5'b10000)   begin bad++; $display("FAIL clr_pre_nv got=%b exp=10000", fflags); end
    FPU_Control = 4'b0011;
    OP_A        = 32'h3F80_0000;
    OP_B        = 32'h8000_0000;
    in_tag      = 5'd11;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL clr_early_valid got=%b exp=0", out_valid); end
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    total++; if (out_valid !== 1'b1)    begin bad++; $display("FAIL clr_div_valid got=%b exp=1", out_valid); end
    total++; if (Result !== 32'hFF80_0000) begin bad++; $display("FAIL clr_div_result got=%h exp=ff800000", Result); end
    total++; if (fflags !== 5'b01000)   begin bad++; $display("FAIL clr_new_wins got=%b exp=01000", fflags); end
    consume();
    clear_flags();
    total++; if (fflags !== 5'b00000)   begin bad++; $display("FAIL clr_after got=%b exp=00000", fflags); end
  endtask

  task automatic test_back_to_back();
    int n;
    run_op(4'b0010, 32'h4000_0000, 32'h4040_0000, 5'd7, n);
    total++; if (n !== 3)               begin bad++; $display("FAIL b2b_mul_latency got=%0d exp=3", n); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (Result !== 32'h40C0_0000) begin bad++; $display("FAIL hold_result[%0d] got=%h exp=40c00000", i, Result); end
      total++; if (out_tag !== 5'd7)    begin bad++; $display("FAIL hold_tag[%0d] got=%0d exp=7", i, out_tag); end
      total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
      total++; if (out_valid !== 1'b1)  begin bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, out_valid); end
    end
    FPU_Control = 4'b0000;
    OP_A        = 32'h3F80_0000;
    OP_B        = 32'h3F80_0000;
    in_tag      = 5'd9;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1)     begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL b2b_exec got=%b exp=0", out_valid); end
    wait_valid(n);
    total++; if (n !== 2)               begin bad++; $display("FAIL b2b_latency got=%0d exp=2", n); end
    total++; if (Result !== 32'h4000_0000) begin bad++; $display("FAIL b2b_result got=%h exp=40000000", Result); end
    total++; if (out_tag !== 5'd9)      begin bad++; $display("FAIL b2b_tag got=%0d exp=9", out_tag); end
    consume();
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    RST         = 1'b1;
    in_valid    = 1'b0;
    OP_A        = 32'h0;
    OP_B        = 32'h0;
    FPU_Control = 4'h0;
    in_tag      = 5'h0;
    out_ready   = 1'b0;
    fflags_clr  = 1'b0;

    test_reset();
    test_add();
    test_misc();
    test_div();
    test_reset_abort();
    test_flag_clr();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_seq_unit.md
# fpu_seq_unit

Sequential, parameterised floating-point execution unit for the RISCVF32 core. It wraps the combinational single-precision FPU datapath behind a valid/ready handshake and gives each operation class its own configurable latency, so multi-cycle pipelines can place multiply and divide on realistic timing. It also adds a sticky exception-flag register (NV, DZ) for the fcsr, and a tag passthrough for writeback routing.

## Interface
- ADD_LAT, default 2: cycles from accept to result for FADD/FSUB (≥1)
- MUL_LAT, default 3: cycles for FMUL (≥1)
- DIV_LAT, default 8: cycles for FDIV (≥1)
- MISC_LAT, default 1: cycles for compare, convert, sign-inject (≥1)
- TAG_W, default 5: width of the opaque tag (destination register index)
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept this cycle
- OP_A  in  32  IEEE-754 single operand A
- OP_B  in  32  IEEE-754 single operand B
- FPU_Control  in  4  operation select, encodings below
- in_tag  in  TAG_W  tag returned with the result
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- Result  out  32  registered result
- out_tag  out  TAG_W  tag of the result
- fflags  out  5  sticky {NV,DZ,OF,UF,NX}; OF/UF/NX are tied 0 in this generation
- fflags_clr  in  1  clears fflags

## Operation
- Encodings: 0000 FADD, 0001 FSUB, 0010 FMUL, 0011 FDIV, 0100 FEQ, 0101 FLT, 0110 FLE, 0111 FCVT.W.S, 1000 FCVT.S.W, 1001 FSGNJ, 1010 FSGNJN, 1011 FSGNJX. Codes 1100–1111 are illegal: accepted, return 0x00000000 with MISC_LAT, set NV.
- FSM: IDLE → EXEC on accept. EXEC → DONE when the counter reaches 0. DONE → IDLE on out_ready. DONE → EXEC on out_ready && in_valid in the same cycle, which gives back-to-back issue.
- Accept = in_valid && in_ready. On accept, register OP_A, OP_B, FPU_Control and in_tag, and load the counter with LAT(class)−1.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- The combinational datapath reads only the captured operand registers. Result and flags are sampled into the output registers in the cycle the counter is 0.
- Result and out_tag hold stable while out_valid && !out_ready.
- NV sets on an accepted FADD/FSUB/FMUL/FDIV/compare with an sNaN operand (exp=0xFF, frac≠0, frac[22]=0). For FDIV, NV also sets on 0/0.
- DZ sets on FDIV with B=±0 and A finite and non-zero.
- Flags OR into fflags when the result registers.
- If fflags_clr coincides with a new flag, the new flag wins: fflags ← new. Otherwise fflags_clr clears fflags to 0.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, Result 0x00000000, out_tag 0, fflags 0, counter 0.
- Latency: accept at edge t gives out_valid high after edge t+LAT, i.e. visible in cycle t+LAT. With LAT=1, out_valid is high in the cycle after accept.
- Only one operation is in flight. No acceptance during EXEC.
- RST mid-EXEC or mid-DONE aborts the operation. The result is discarded, no flags are updated, and all outputs take their reset values on the next edge.
- If out_ready is high while out_valid is low, it is ignored.
- in_valid with in_ready low is not accepted. The upstream stage must hold its inputs stable.

## Structure
- Shared package fpu_pkg holds:
  - FPU_Control encoding localparams
  - op-class enum {ADDSUB, MUL, DIV, MISC}
  - function op_class(ctrl)
  - FSM state typedef
  - flag bit index constants
- One sub-module: the existing combinational FPU datapath FPU, instantiated unchanged on the captured operand registers.
- This unit adds the FSM, latency counter, output and flag registers, and the exception detector (about 200 lines).

## Test plan
- ADD_LAT=2, FADD 0x3F800000+0x40000000 accepted in cycle 0 → out_valid in cycle 2, Result 0x40400000, fflags 0.
- DIV_LAT=8, FDIV 0x3F800000/0x00000000 → out_valid in cycle 8, Result 0x7F800000, fflags 5'b01000. FDIV 0/0 → fflags 5'b11000 (sticky).
- out_ready held low 5 cycles after out_valid → Result and out_tag stable, in_ready 0. Raise out_ready together with in_valid → new op accepted that cycle.
- RST asserted 3 cycles into an 8-cycle FDIV → next cycle out_valid 0, in_ready 1, fflags 0. A subsequent FMUL 2.0×3.0 returns 0x40C00000 after MUL_LAT.
- fflags_clr in the same cycle as a DZ result → fflags 5'b01000. fflags_clr alone → 0.
- Illegal code 4'b1111 → Result 0x00000000 after MISC_LAT, NV set. FEQ with sNaN 0x7FA00000 → Result 0, NV set.
